decode_issue: RTL and testbench

- Decode/issue stage directly upstream of the 16-entry register file (r0 hard-wired zero, synchronous read, 1-cycle read latency).
- Accepts 16-bit instruction words from fetch and drives the register file read selects.
- Tracks outstanding register writes in a scoreboard and stalls on hazards.
- Presents a one-entry issued-instruction register to execute, aligned with the register file read data.

---
 rtl/decode_issue_if.sv | 29 ++
 rtl/decode_issue.sv | 95 +++++++++
 tb/tb_decode_issue.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Handshake and bus signals between fetch, decode/issue, register file,
// execute and writeback. The decode/issue stage uses the slave modport.
interface decode_issue_if;
  logic [15:0] i_instr;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic [3:0]  o_selectA;
  logic [3:0]  o_selectB;
  logic        o_ex_valid;
  logic        i_ex_ready;
  logic [3:0]  o_ex_opcode;
  logic [3:0]  o_ex_rd;
  logic        o_ex_we;
  logic        i_wb_en;
  logic [3:0]  i_wb_sel;
  logic [15:0] o_busy;

  modport slave (
    input  i_instr, i_instr_valid, i_ex_ready, i_wb_en, i_wb_sel,
    output o_instr_ready, o_selectA, o_selectB, o_ex_valid,
           o_ex_opcode, o_ex_rd, o_ex_we, o_busy
  );

  modport master (
    output i_instr, i_instr_valid, i_ex_ready, i_wb_en, i_wb_sel,
    input  o_instr_ready, o_selectA, o_selectB, o_ex_valid,
           o_ex_opcode, o_ex_rd, o_ex_we, o_busy
  );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: scoreboarded hazard stall, register file read select
// steering, and a one-entry issue register aligned with register file data.
module decode_issue #(
  parameter logic [15:0] WRITE_MASK = 16'hFFF0
) (
  input logic           i_clk,
  input logic           i_reset,
  decode_issue_if.slave bus
);

  logic [3:0]  op, rd, rs1, rs2;
  logic        instr_we;
  logic        hazard;
  logic        ready;
  logic        accept;
  logic [15:0] busy_q;
  logic [15:0] set_vec;
  logic [15:0] clr_vec;
  logic [3:0]  held_a_q, held_b_q;
  logic        ex_valid_q;
  logic [3:0]  ex_opcode_q, ex_rd_q;
  logic        ex_we_q;

  assign op  = bus.i_instr[15:12];
  assign rd  = bus.i_instr[11:8];
  assign rs1 = bus.i_instr[7:4];
  assign rs2 = bus.i_instr[3:0];

  // Hazard check uses the registered scoreboard only: a bit being cleared by
  // writeback this cycle is still busy because the register file has no bypass.
  always_comb begin
    instr_we = WRITE_MASK[op] && (rd != 4'd0);
    hazard   = ((rs1 != 4'd0) && busy_q[rs1]) ||
               ((rs2 != 4'd0) && busy_q[rs2]) ||
               (instr_we && busy_q[rd]);
    ready    = !hazard && (!ex_valid_q || bus.i_ex_ready);
    accept   = bus.i_instr_valid && ready;
  end

  // Scoreboard set/clear vectors; r0 never tracked, set wins over clear.
  always_comb begin
    set_vec = 16'h0000;
    clr_vec = 16'h0000;
    if (accept && instr_we)
      set_vec = 16'h0001 << rd;
    if (bus.i_wb_en && (bus.i_wb_sel != 4'd0))
      clr_vec = 16'h0001 << bus.i_wb_sel;
  end

  // Scoreboard register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      busy_q <= 16'h0000;
    else
      busy_q <= (busy_q & ~clr_vec) | set_vec;
  end

  // Held read selects keep register file data stable while the issue slot is held.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      held_a_q <= 4'd0;
      held_b_q <= 4'd0;
    end else if (accept) begin
      held_a_q <= rs1;
      held_b_q <= rs2;
    end
  end

  // Issue register: load on accept, drain when execute consumes, else hold.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= 4'd0;
      ex_rd_q     <= 4'd0;
      ex_we_q     <= 1'b0;
    end else if (accept) begin
      ex_valid_q  <= 1'b1;
      ex_opcode_q <= op;
      ex_rd_q     <= rd;
      ex_we_q     <= instr_we;
    end else if (bus.i_ex_ready) begin
      ex_valid_q  <= 1'b0;
    end
  end

  assign bus.o_instr_ready = ready;
  assign bus.o_selectA     = accept ? rs1 : held_a_q;
  assign bus.o_selectB     = accept ? rs2 : held_b_q;
  assign bus.o_ex_valid    = ex_valid_q;
  assign bus.o_ex_opcode   = ex_opcode_q;
  assign bus.o_ex_rd       = ex_rd_q;
  assign bus.o_ex_we       = ex_we_q;
  assign bus.o_busy        = busy_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios plus randomized traffic, all
// compared against a register-level reference model of the stage.
module tb_decode_issue;

  localparam logic [15:0] WMASK = 16'hFFF0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  decode_issue_if bus ();

  decode_issue dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit       pending [16];
  bit       m_ex_valid;
  bit [3:0] m_ex_op, m_ex_rd;
  bit       m_ex_we;
  bit [3:0] m_hold_a, m_hold_b;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) pending[r] = 1'b0;
    m_ex_valid = 0; m_ex_op = 0; m_ex_rd = 0; m_ex_we = 0;
    m_hold_a = 0; m_hold_b = 0;
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] v = 16'h0;
    for (int r = 1; r < 16; r++) if (pending[r]) v = v + (16'd1 << r);
    return v;
  endfunction

  // One cycle: apply inputs, compare everything mid-cycle, advance the model.
  task automatic cycle(input logic [15:0] instr, input logic v, input logic exr,
                       input logic wbe, input logic [3:0] wbs);
    int  op, rd, s1, s2;
    bit  writes, stall, rdy, acc;
    bus.i_instr = instr; bus.i_instr_valid = v; bus.i_ex_ready = exr;
    bus.i_wb_en = wbe;   bus.i_wb_sel = wbs;
    op = int'(instr[15:12]); rd = int'(instr[11:8]);
    s1 = int'(instr[7:4]);   s2 = int'(instr[3:0]);
    writes = (WMASK[op] == 1'b1) && (rd != 0);
    stall  = (s1 != 0 && pending[s1]) || (s2 != 0 && pending[s2]) || (writes && pending[rd]);
    rdy    = !stall && (!m_ex_valid || exr);
    acc    = v && rdy;
    #2;
    if (v) check_eq("ready", {15'd0, bus.o_instr_ready}, {15'd0, rdy});
    check_eq("selA", {12'd0, bus.o_selectA}, {12'd0, acc ? instr[7:4] : m_hold_a});
    check_eq("selB", {12'd0, bus.o_selectB}, {12'd0, acc ? instr[3:0] : m_hold_b});
    check_eq("ex_valid", {15'd0, bus.o_ex_valid}, {15'd0, m_ex_valid});
    check_eq("ex_opcode", {12'd0, bus.o_ex_opcode}, {12'd0, m_ex_op});
    check_eq("ex_rd", {12'd0, bus.o_ex_rd}, {12'd0, m_ex_rd});
    check_eq("ex_we", {15'd0, bus.o_ex_we}, {15'd0, m_ex_we});
    check_eq("busy", bus.o_busy, model_busy());
    if (wbe && wbs != 0) pending[wbs] = 1'b0;
    if (acc && writes) pending[rd] = 1'b1;
    if (acc) begin
      m_ex_valid = 1; m_ex_op = instr[15:12]; m_ex_rd = instr[11:8]; m_ex_we = writes;
      m_hold_a = instr[7:4]; m_hold_b = instr[3:0];
    end else if (exr) begin
      m_ex_valid = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.i_instr = 16'h0; bus.i_instr_valid = 0; bus.i_ex_ready = 0;
    bus.i_wb_en = 0; bus.i_wb_sel = 0;
    model_reset();
    #12;
    check_eq("rst_ex_valid", {15'd0, bus.o_ex_valid}, 16'h0);
    check_eq("rst_busy", bus.o_busy, 16'h0);
    check_eq("rst_selA", {12'd0, bus.o_selectA}, 16'h0);
    check_eq("rst_selB", {12'd0, bus.o_selectB}, 16'h0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: basic issue
    cycle(16'h4312, 1, 1, 0, 0);
    check_eq("t1_busy", bus.o_busy, 16'h0008);
    check_eq("t1_ex_rd", {12'd0, bus.o_ex_rd}, 16'd3);
    // 2: RAW stall, clear in same cycle still stalls
    cycle(16'h5530, 1, 1, 0, 0);
    cycle(16'h5530, 1, 1, 1, 4'd3);
    check_eq("t2_busy", bus.o_busy, 16'h0000);
    cycle(16'h5530, 1, 1, 0, 0);
    // 3: back-pressure holds issue slot and selects
    cycle(16'h4312, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(16'h6120, 1, 0, 0, 0);
    check_eq("t3_selA_held", {12'd0, bus.o_selectA}, 16'd1);
    cycle(16'h6120, 1, 1, 0, 0);
    check_eq("t3_ex_op", {12'd0, bus.o_ex_opcode}, 16'd6);
    // 4: non-writing instructions
    cycle(16'h0000, 0, 1, 1, 4'd1);
    cycle(16'h0000, 0, 1, 1, 4'd3);
    cycle(16'h0000, 0, 1, 1, 4'd5);
    cycle(16'h0712, 1, 1, 0, 0);
    check_eq("t4_we_op0", {15'd0, bus.o_ex_we}, 16'h0);
    cycle(16'h4012, 1, 1, 0, 0);
    check_eq("t4_we_rd0", {15'd0, bus.o_ex_we}, 16'h0);
    check_eq("t4_busy", bus.o_busy, 16'h0000);
    // 5: WAW stall and stray clears
    cycle(16'h4500, 1, 1, 0, 0);
    cycle(16'h4500, 1, 1, 1, 4'd0);
    cycle(16'h4500, 1, 1, 1, 4'd9);
    check_eq("t5_busy", bus.o_busy, 16'h0020);
    // 6: async reset mid-cycle
    cycle(16'h4700, 1, 0, 0, 0);
    check_eq("t6_busy_pre", bus.o_busy, 16'h00A0);
    bus.i_instr_valid = 0;
    #3; rst = 1'b1; #1;
    check_eq("t6_ex_valid", {15'd0, bus.o_ex_valid}, 16'h0);
    check_eq("t6_busy", bus.o_busy, 16'h0);
    check_eq("t6_selA", {12'd0, bus.o_selectA}, 16'h0);
    check_eq("t6_selB", {12'd0, bus.o_selectB}, 16'h0);
    model_reset();
    @(posedge clk); #1; rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle(16'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
